// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester port of the data-memory arbiter (CPU LSU or debug loader).
//
//   Handshake: the requester raises req together with we/addr/wdata and holds
//   all four unchanged until it sees gnt=1. The command is taken at the rising
//   clock edge where req & gnt = 1; fields may change only after that edge.
//   gnt is combinational from arbiter state and req. Read responses come back
//   as a single-cycle rvalid pulse with rdata, two edges after acceptance;
//   rdata then holds until the next read response on this port.
//
//   Signals:
//     req    requester -> arbiter  command valid
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  access address (AW bits)
//     wdata  requester -> arbiter  write data (DW bits)
//     lock   requester -> arbiter  exclusive-hold request (DMEM_ARB_LOCK_EN only)
//     gnt    arbiter -> requester  command accept
//     rvalid arbiter -> requester  one-cycle read-data-valid pulse
//     rdata  arbiter -> requester  registered read data
//
//   Optional macro: DMEM_ARB_LOCK_EN adds the lock signal.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock;

  modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
`else
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port round-robin arbiter and access sequencer in front of a
//   single-port data memory (combinational read, posedge write).
//   Port A is the CPU load/store unit, port B the debug/loader requester.
//
//   Flow: a command accepted at edge E is latched; the cycle after E (ACC)
//   drives the memory controls; at E+1 a write commits in memory and a read
//   is captured into the owner's rdata, with rvalid high the cycle after E+1.
//   A new command can be accepted at E+1, giving one access per cycle.
//
//   Ports:
//     clk, rst_n        clock (rising edge), async active-low reset
//     port_a, port_b    requester interfaces (slave modport)
//     mem_access_addr   memory address (held outside ACC)
//     mem_write_data    memory write data (held outside ACC)
//     mem_write_en      memory write strobe, ACC cycle of a write only
//     mem_read          memory read strobe, ACC cycle of a read only
//     mem_read_data     memory read data
//     o_dbg_state       FSM state (0 = IDLE, 1 = ACC)
//
//   Parameters: AW address width, DW data width, FIRST_PRIO port that wins
//   the first tie after reset (0 = A, 1 = B).
//
//   Optional macro: DMEM_ARB_LOCK_EN. When defined, a port accepted with
//   lock=1 keeps exclusive grant while its lock stays high and the
//   round-robin pointer is frozen.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave port_a,
  dmem_arbiter_if.slave port_b,
  output logic [AW-1:0] mem_access_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_en,
  output logic          mem_read,
  input  logic [DW-1:0] mem_read_data,
  output logic          o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_rr;        // port that wins a tie: 0 = A, 1 = B
  logic          r_port;      // owner of the latched command
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_accept;
  logic          w_mem_we;
  logic          w_mem_rd;
  logic          w_locked;    // a lock owner currently holds exclusive grant
  logic          w_lock_port;

  // ---------------------------------------------------------------------------
  // Lock ownership
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_LOCK_EN
  logic r_lock_valid;
  logic r_lock_port;

  // Ownership only counts while the owner keeps lock high, so release is
  // visible in the same cycle lock drops.
  assign w_lock_port = r_lock_port;
  assign w_locked    = r_lock_valid & (r_lock_port ? port_b.lock : port_a.lock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_valid <= 1'b0;
      r_lock_port  <= 1'b0;
    end else if (w_accept) begin
      // Ownership is only ever taken on an acceptance.
      r_lock_valid <= w_gnt_b ? port_b.lock : port_a.lock;
      r_lock_port  <= w_gnt_b;
    end else if (!w_locked) begin
      r_lock_valid <= 1'b0;
    end
  end
`else
  assign w_lock_port = 1'b0;
  assign w_locked    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: combinational from registered state and req; gnt is held
  // low while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_n) begin
      if (w_locked) begin
        if (w_lock_port) w_gnt_b = port_b.req;
        else             w_gnt_a = port_a.req;
      end else if (port_a.req && port_b.req) begin
        if (r_rr) w_gnt_b = 1'b1;
        else      w_gnt_a = 1'b1;
      end else begin
        w_gnt_a = port_a.req;
        w_gnt_b = port_b.req;
      end
    end
  end

  assign w_accept = w_gnt_a | w_gnt_b;

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_rd     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_ACC;
      end
      ST_ACC: begin
        w_mem_we     = r_we;
        w_mem_rd     = ~r_we;
        w_next_state = w_accept ? ST_ACC : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command register, round-robin pointer and read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= FIRST_PRIO;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_mem_rd & ~r_port;
      r_b_rvalid <= w_mem_rd & r_port;
      if (w_mem_rd && !r_port) r_a_rdata <= mem_read_data;
      if (w_mem_rd &&  r_port) r_b_rdata <= mem_read_data;
      if (w_accept) begin
        r_port  <= w_gnt_b;
        r_we    <= w_gnt_b ? port_b.we    : port_a.we;
        r_addr  <= w_gnt_b ? port_b.addr  : port_a.addr;
        r_wdata <= w_gnt_b ? port_b.wdata : port_a.wdata;
        // Priority passes to the port that was not served; frozen under lock.
        if (!w_locked) r_rr <= ~w_gnt_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign port_a.gnt    = w_gnt_a;
  assign port_b.gnt    = w_gnt_b;
  assign port_a.rvalid = r_a_rvalid;
  assign port_b.rvalid = r_b_rvalid;
  assign port_a.rdata  = r_a_rdata;
  assign port_b.rdata  = r_b_rdata;

  assign mem_access_addr = r_addr;
  assign mem_write_data  = r_wdata;
  assign mem_write_en    = w_mem_we;
  assign mem_read        = w_mem_rd;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port Data_Memory (8 x 8-bit, combinational read, posedge write).
- Port A is the CPU load/store unit; port B is the debug/loader requester.
- Accepts req/gnt commands, arbitrates round-robin, drives the memory control signals one cycle after acceptance, and returns registered read data with a one-cycle rvalid pulse to the owning port.

Parameters:
- AW, 8, address width, passed through unmodified (memory decodes [2:0]).
- DW, 8, data width.
- FIRST_PRIO, 0, port that wins the first tie after reset (0=A, 1=B).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req / b_req  in  1  command valid, held until accepted.
- a_we / b_we  in  1  1=write, 0=read.
- a_addr / b_addr  in  AW  access address.
- a_wdata / b_wdata  in  DW  write data.
- a_gnt / b_gnt  out  1  combinational accept; command taken at the edge where req&gnt=1.
- a_rvalid / b_rvalid  out  1  one-cycle read-data-valid pulse.
- a_rdata / b_rdata  out  DW  registered read data, held until that port's next read response.
- mem_access_addr  out  AW  to memory.
- mem_write_data  out  DW  to memory.
- mem_write_en  out  1  to memory.
- mem_read  out  1  to memory.
- mem_read_data  in  DW  from memory.
- a_lock / b_lock  in  1  present only with DMEM_ARB_LOCK_EN.

Behaviour:
- Reset (async, rst_n low): all outputs 0, including gnt (forced 0 while rst_n low) and rdata. Command register cleared. RR pointer set to FIRST_PRIO. An in-flight write is dropped; mem_write_en falls immediately.
- Arbitration is combinational from registered state:
  - Only one req high: that port gets gnt.
  - Both high: port selected by the RR pointer wins; the loser's gnt=0.
  - At most one gnt high per cycle.
  - On each acceptance the pointer moves to the other port.
- Stage 1 (edge E, req&gnt): latch port id, we, addr, wdata; state IDLE->ACC.
- ACC cycle (between E and E+1):
  - mem_access_addr = latched addr.
  - Write: mem_write_en=1, mem_write_data=wdata, mem_read=0.
  - Read: mem_read=1, mem_write_en=0.
- Edge E+1:
  - Write commits in memory.
  - Read: mem_read_data is captured into the owner's rdata, and that port's rvalid=1 for the cycle after E+1.
  - Read latency is 2 edges from acceptance; writes return no response.
- Pipelining: a new command may be accepted at E+1 (ACC->ACC), so throughput is 1 access/cycle. With no accepted req, ACC->IDLE.
- Outside ACC: mem_write_en=0, mem_read=0, address/data outputs hold their last values.
- Write to X followed back-to-back by a read of X returns the new data (write commits before the read's ACC cycle). No forwarding is needed.
- A requester may change addr/we/wdata only after acceptance; changing them while req=1 and gnt=0 is a protocol violation (the bench asserts on it).
- Address bits above [2:0] pass through; aliasing is the memory's concern.

Optional Feature:
- DMEM_ARB_LOCK_EN.
  - Defined: a_lock/b_lock exist. If a port is accepted with lock=1, it retains exclusive grant on following cycles while its lock stays 1: the other port's gnt=0, and the RR pointer is frozen. Lock release takes effect the cycle lock drops. Lock asserted without a current grant has no effect. Reset clears lock ownership.
  - Undefined: the lock ports are absent; pure round-robin.

Test Plan:
- Reset then a_req write addr=3 wdata=8'hA5 -> a_gnt same cycle, mem_write_en=1 with addr 3 next cycle; later a_req read addr=3 -> a_rvalid 2 edges after accept, a_rdata=8'hA5.
- a_req and b_req both held from reset, FIRST_PRIO=0, reads of addr 1 and 2 -> grants A,B,A,B alternating every cycle; rvalid pulses alternate, one access per cycle.
- B write addr=5 data=8'h3C accepted, A read addr=5 accepted next edge -> a_rdata=8'h3C.
- rst_n low during an ACC write to addr 6 (pre-value 8'h11) -> mem_write_en drops immediately, memory[6] stays 8'h11, all rvalid/gnt 0, the next arbitration favours FIRST_PRIO.
- Only b_req pulsed for 1 cycle read addr 0 -> b_gnt=1, mem_read=1 exactly one cycle, b_rvalid one cycle, a_rvalid stays 0, mem_read=0 afterward.
- With DMEM_ARB_LOCK_EN: A accepted with a_lock=1 for 4 cycles while b_req held -> b_gnt=0 for those cycles; first b_gnt the cycle a_lock drops.
